imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time loader upstream of the single-cycle core. Receives a byte stream (2-byte word count, then
//  little-endian 32-bit instruction words), writes each word into instruction memory, and holds the
//  core in reset until the load finishes. Sits between the external byte source and the core's imem
//  write port and reset input.
// PARAMETERS
//  DEPTH       1024  instruction memory size in 32-bit words; legal count range is 0..DEPTH
//  CNT_W       16    width of the word-count field in the stream (fixed 2 bytes)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   1-cycle pulse; begins a load when in IDLE
//  in_valid     in   1   byte source has a byte on in_data
//  in_data      in   8   stream byte
//  in_ready     out  1   loader accepts a byte this cycle (transfer = in_valid & in_ready)
//  imem_we      out  1   instruction memory write strobe, 1-cycle pulse per word
//  imem_addr    out  32  byte address of write = word_index*4
//  imem_wdata   out  32  assembled instruction word
//  core_rst     out  1   reset to core, active-low (0 = core held), matches core's rst convention
//  done         out  1   load completed, core released
//  err          out  1   count exceeded DEPTH; sticky until rst
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, err=0;
//    byte/word counters cleared. rst mid-load aborts immediately; words already written stay in memory.
//  - FSM: IDLE -> LEN_LO -> LEN_HI -> DATA <-> WRITE -> RUN; LEN_HI -> ERR on bad count.
//    IDLE:   in_ready=0; start=1 -> LEN_LO. Bytes ignored.
//    LEN_LO: in_ready=1; on transfer count[7:0]=in_data -> LEN_HI.
//    LEN_HI: in_ready=1; on transfer count[15:8]=in_data; count==0 -> RUN; count>DEPTH -> ERR;
//            else -> DATA with byte_idx=0, word_idx=0.
//    DATA:   in_ready=1; transfer k (k=0..3) places in_data at wdata[8k+7:8k]; 4th byte -> WRITE.
//    WRITE:  in_ready=0; imem_we=1 for exactly this cycle, imem_addr=word_idx*4, imem_wdata=word;
//            word_idx++; word_idx+1==count -> RUN else -> DATA.
//    RUN:    core_rst=1, done=1, in_ready=0; start and in_valid ignored; exits only on rst.
//    ERR:    err=1, core_rst=0, in_ready=0, imem_we never asserted; exits only on rst.
//  - Latency: 4th data byte accepted in cycle t -> imem_we in t+1; last write in cycle w -> core_rst=1,
//    done=1 from cycle w+1. Zero-count: LEN_HI transfer in t -> core_rst=1 at t+1.
//  - Gaps: in_valid may drop anytime; partial word/byte index held, no timeout.
//  - start while not IDLE ignored. start and rst same cycle: rst wins.
//  - count==DEPTH legal (last addr (DEPTH-1)*4); count==DEPTH+1 -> ERR.
//  - imem_addr/imem_wdata hold last written values outside WRITE; only imem_we qualifies them.
//  - core_rst registered, glitch-free, 0 in every state except RUN.
// TESTING
//  1 rst, start, stream 02 00 | 13 00 00 00 | 93 00 10 00 -> we pulses: addr 0 data 0x00000013,
//    addr 4 data 0x00100093; core_rst=1, done=1 cycle after 2nd write.
//  2 stream 00 00 -> no imem_we; core_rst=1 cycle after 2nd length byte; done=1.
//  3 DEPTH=4, count 05 00 -> err=1, core_rst stays 0, in_ready=0, no writes; count 04 00 -> 4 writes,
//    last addr 0x0C.
//  4 in_valid toggled 1/0 every cycle during 1-word load DE AD BE EF -> single write 0xEFBEADDE,
//    no byte lost or duplicated; in_ready=0 in WRITE cycle.
//  5 rst asserted after 2 of 4 data bytes -> next cycle IDLE, core_rst=0, no write; fresh start
//    reloads from addr 0 correctly.
//  6 bytes with in_valid=1 before start and after RUN -> ignored (in_ready=0), no writes, state unchanged.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot-time instruction loader: takes a 2-byte word count followed by little-endian words,
// writes them into instruction memory and keeps the core in reset until the load completes.
module imem_boot_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_RUN, S_ERR
  } state_e;

  localparam logic [31:0] DEPTH_C = 32'(DEPTH);

  state_e           state_q, state_d;
  logic [7:0]       cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] word_idx_inc;
  logic [CNT_W-1:0] len_in;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             core_rst_q, done_q, err_q;

  assign len_in       = CNT_W'({in_data, cnt_lo_q});
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          count_d = len_in;
          if (len_in == '0) begin
            state_d = S_RUN;
          end else if (32'(len_in) > DEPTH_C) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
            word_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            2'd3: begin
              // Output registers load here so they are valid during WRITE and hold afterwards.
              addr_d  = 32'({word_idx_q, 2'b00});
              wdata_d = {in_data, word_q};
              state_d = S_WRITE;
            end
            default: ;
          endcase
        end
      end
      S_WRITE: begin
        imem_we    = 1'b1;
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? S_RUN : S_DATA;
      end
      S_RUN: ;
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= (state_d == S_RUN);
      done_q     <= (state_d == S_RUN);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (DEPTH=4 so the count limit is reachable).
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, core_rst, done, err;
  logic [31:0] imem_addr, imem_wdata;

  int total = 0;
  int bad   = 0;
  int we_rdy_bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  imem_boot_loader #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      if (in_ready !== 1'b0) we_rdy_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wa.delete(); wd.delete(); we_rdy_bad = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL byte_accept: in_ready=%b expected 1 for byte %h", in_ready, b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 8'hxx;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b expected 0", imem_we); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h expected 0", imem_wdata); end
    total++; if ({core_rst, done, err} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b expected 000", {core_rst, done, err}); end
    // start coincident with rst must be dropped
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_wins_start: in_ready got %b expected 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_two_words();
    do_reset();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    @(negedge clk);
    total++; if ({imem_we, core_rst} !== 2'b10) begin bad++; $display("FAIL two_last_write: we,core_rst got %b expected 10", {imem_we, core_rst}); end
    @(negedge clk);
    total++; if ({core_rst, done, imem_we} !== 3'b110) begin bad++; $display("FAIL two_release: core_rst,done,we got %b expected 110", {core_rst, done, imem_we}); end
    total++;
    if (wa.size() !== 2) begin bad++; $display("FAIL two_count: got %0d writes expected 2", wa.size()); end
    else if (wa[0] !== 32'h0 || wd[0] !== 32'h00000013 || wa[1] !== 32'h4 || wd[1] !== 32'h00100093) begin
      bad++; $display("FAIL two_data: got %h:%h %h:%h expected 00000000:00000013 00000004:00100093", wa[0], wd[0], wa[1], wd[1]);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    total++; if ({core_rst, done, err} !== 3'b110) begin bad++; $display("FAIL zero_release: core_rst,done,err got %b expected 110", {core_rst, done, err}); end
    repeat (3) @(negedge clk);
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d expected 0", wa.size()); end
  endtask

  task automatic test_count_limit();
    logic [31:0] exp;
    do_reset();
    pulse_start();
    send_byte(8'h05); send_byte(8'h00);
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (4) @(negedge clk);
    total++; if ({err, core_rst, in_ready, done} !== 4'b1000) begin bad++; $display("FAIL over_by_one: err,core_rst,in_ready,done got %b expected 1000", {err, core_rst, in_ready, done}); end
    in_valid = 1'b0;
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL over_writes: got %0d expected 0", wa.size()); end
    // high byte alone pushes count far past the limit
    do_reset();
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    total++; if ({err, core_rst} !== 2'b10) begin bad++; $display("FAIL over_hi: err,core_rst got %b expected 10", {err, core_rst}); end
    // exactly DEPTH words is legal
    do_reset();
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) send_byte(8'(w * 4 + b));
    repeat (2) @(negedge clk);
    total++; if ({core_rst, done, err} !== 3'b110) begin bad++; $display("FAIL full_release: core_rst,done,err got %b expected 110", {core_rst, done, err}); end
    total++;
    if (wa.size() !== 4) begin bad++; $display("FAIL full_count: got %0d writes expected 4", wa.size()); end
    else if (wa[3] !== 32'h0000000C) begin bad++; $display("FAIL full_last_addr: got %h expected 0000000c", wa[3]); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      exp = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      total++;
      if (wa[i] !== 32'(4 * i) || wd[i] !== exp) begin
        bad++; $display("FAIL full_word%0d: got %h:%h expected %h:%h", i, wa[i], wd[i], 32'(4 * i), exp);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [4];
    bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
    do_reset();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      if (i < 3) begin
        in_data = 8'h77;
        @(posedge clk); #1;
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() !== 1) begin bad++; $display("FAIL gap_count: got %0d writes expected 1", wa.size()); end
    else if (wa[0] !== 32'h0 || wd[0] !== 32'hEFBEADDE) begin bad++; $display("FAIL gap_word: got %h:%h expected 00000000:efbeadde", wa[0], wd[0]); end
    total++; if (we_rdy_bad !== 0) begin bad++; $display("FAIL gap_ready_in_write: got %0d cycles expected 0", we_rdy_bad); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap_done: got %b expected 1", done); end
  endtask

  task automatic test_abort();
    do_reset();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({core_rst, in_ready, done, imem_we} !== 4'b0000) begin bad++; $display("FAIL abort_idle: core_rst,in_ready,done,we got %b expected 0000", {core_rst, in_ready, done, imem_we}); end
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL abort_writes: got %0d expected 0", wa.size()); end
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() !== 1) begin bad++; $display("FAIL reload_count: got %0d writes expected 1", wa.size()); end
    else if (wa[0] !== 32'h0 || wd[0] !== 32'h44332211) begin bad++; $display("FAIL reload_word: got %h:%h expected 00000000:44332211", wa[0], wd[0]); end
  endtask

  task automatic test_ignored_bytes();
    do_reset();
    in_valid = 1'b1; in_data = 8'h03;
    repeat (3) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b expected 0", in_ready); end
    end
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_data = 8'h99; start = 1'b1;
    repeat (4) @(negedge clk);
    total++; if ({in_ready, done, core_rst, imem_we} !== 4'b0110) begin bad++; $display("FAIL run_ignore: in_ready,done,core_rst,we got %b expected 0110", {in_ready, done, core_rst, imem_we}); end
    in_valid = 1'b0; start = 1'b0;
    total++; if (imem_addr !== 32'h0 || imem_wdata !== 32'hD4C3B2A1) begin bad++; $display("FAIL run_hold: got %h:%h expected 00000000:d4c3b2a1", imem_addr, imem_wdata); end
    total++; if (wa.size() !== 1) begin bad++; $display("FAIL run_writes: got %0d expected 1", wa.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_two_words();
    test_zero_count();
    test_count_limit();
    test_gaps();
    test_abort();
    test_ignored_bytes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
